// File: rtl/rop_rmw_ctrl_if.sv
// ---------------------------------------------------------------------------
// rop_rmw_ctrl_if
// Bundles every handshake and data signal of the ROP read-modify-write
// controller: fragment input, framebuffer read request/response, blender
// issue/result, framebuffer write, and status.
//   master : the controller side (drives frag_ready, rd_req_*, blend_*,
//            wr_valid/addr/data, busy, err_rsp)
//   slave  : the environment side (shader, memory, blender)
// ---------------------------------------------------------------------------
interface rop_rmw_ctrl_if #(
  parameter int ADDR_W = 16
);
  logic              frag_valid;
  logic              frag_ready;
  logic [ADDR_W-1:0] frag_addr;
  logic [31:0]       frag_src0;
  logic [31:0]       frag_src1;
  logic [3:0]        frag_fsel;
  logic              rd_req_valid;
  logic              rd_req_ready;
  logic [ADDR_W-1:0] rd_req_addr;
  logic              rd_rsp_valid;
  logic [31:0]       rd_rsp_data;
  logic              blend_valid;
  logic [31:0]       blend_src0;
  logic [31:0]       blend_src1;
  logic [31:0]       blend_dst;
  logic [3:0]        blend_fsel;
  logic              blend_out_valid;
  logic [31:0]       blend_out_color;
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              busy;
  logic              err_rsp;

  modport master (
    input  frag_valid, frag_addr, frag_src0, frag_src1, frag_fsel,
    output frag_ready,
    output rd_req_valid, rd_req_addr,
    input  rd_req_ready, rd_rsp_valid, rd_rsp_data,
    output blend_valid, blend_src0, blend_src1, blend_dst, blend_fsel,
    input  blend_out_valid, blend_out_color,
    output wr_valid, wr_addr, wr_data,
    input  wr_ready,
    output busy, err_rsp
  );

  modport slave (
    output frag_valid, frag_addr, frag_src0, frag_src1, frag_fsel,
    input  frag_ready,
    input  rd_req_valid, rd_req_addr,
    output rd_req_ready, rd_rsp_valid, rd_rsp_data,
    input  blend_valid, blend_src0, blend_src1, blend_dst, blend_fsel,
    output blend_out_valid, blend_out_color,
    input  wr_valid, wr_addr, wr_data,
    output wr_ready,
    input  busy, err_rsp
  );
endinterface

// File: rtl/rop_rmw_ctrl.sv
// ---------------------------------------------------------------------------
// rop_rmw_ctrl
// Read-modify-write sequencer for the raster-op stage. Fragments are queued
// in a circular DEPTH-entry pending buffer; each entry reads its destination
// colour, is sent once to the blender, and the blended colour is written back
// in fragment-accept order. A fragment whose address matches any occupied
// entry is stalled so same-address fragments never overlap.
// Ports:
//   clk   : clock, all state on the rising edge
//   rst_n : synchronous active-low reset
//   bus   : rop_rmw_ctrl_if.master (fragment, read, blend, write, status)
// ---------------------------------------------------------------------------
module rop_rmw_ctrl #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  rop_rmw_ctrl_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // pending buffer
  logic [ADDR_W-1:0] addr_r [DEPTH];
  logic [31:0]       src0_r [DEPTH];
  logic [31:0]       src1_r [DEPTH];
  logic [3:0]        fsel_r [DEPTH];
  logic [31:0]       dst_r  [DEPTH];
  logic [DEPTH-1:0]  occ_r;
  logic [DEPTH-1:0]  dst_ok_r;

  logic [PW-1:0] alloc_r, issue_r, rsp_r, blend_r, retire_r;
  // pointer gaps are tracked as counts so a full buffer is never mistaken
  // for an empty one when two pointers coincide
  logic [CW-1:0] count_r, pend_rd_r, out_rd_r;

  logic              ready_en_r;
  logic              in_flight_r;
  logic              blend_valid_r;
  logic [31:0]       blend_src0_r, blend_src1_r, blend_dst_r;
  logic [3:0]        blend_fsel_r;
  logic [ADDR_W-1:0] blend_addr_r;
  logic              wr_valid_r;
  logic [ADDR_W-1:0] wr_addr_r;
  logic [31:0]       wr_data_r;
  logic              err_rsp_r;

  logic hazard_s, frag_ready_s, acc_s, rd_go_s, rsp_ok_s, rsp_err_s;
  logic blend_rdy_s, blend_go_s, wr_go_s, res_load_s;

  // address hazard against every occupied entry, including one retiring now
  always_comb begin
    hazard_s = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (occ_r[i] && (addr_r[i] == bus.frag_addr)) begin
        hazard_s = 1'b1;
      end else begin
        hazard_s = hazard_s;
      end
    end
  end

  // blend candidate: response already stored, or arriving this cycle (bypass)
  always_comb begin
    if (dst_ok_r[blend_r]) begin
      blend_rdy_s = 1'b1;
    end else if (rsp_ok_s && (rsp_r == blend_r)) begin
      blend_rdy_s = 1'b1;
    end else begin
      blend_rdy_s = 1'b0;
    end
  end

  assign frag_ready_s = ready_en_r && (count_r < CW'(DEPTH)) && !hazard_s;
  assign acc_s        = bus.frag_valid && frag_ready_s;
  assign rd_go_s      = (pend_rd_r != CW'(0)) && bus.rd_req_ready;
  assign rsp_ok_s     = bus.rd_rsp_valid && (out_rd_r != CW'(0));
  assign rsp_err_s    = bus.rd_rsp_valid && (out_rd_r == CW'(0));
  assign blend_go_s   = blend_rdy_s && !in_flight_r && !wr_valid_r;
  assign res_load_s   = in_flight_r && bus.blend_out_valid;
  assign wr_go_s      = wr_valid_r && bus.wr_ready;

  // all controller state: buffer, pointers, blend issue, write holding register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_r[i] <= '0;
        src0_r[i] <= 32'h0;
        src1_r[i] <= 32'h0;
        fsel_r[i] <= 4'h0;
        dst_r[i]  <= 32'h0;
      end
      occ_r         <= '0;
      dst_ok_r      <= '0;
      alloc_r       <= '0;
      issue_r       <= '0;
      rsp_r         <= '0;
      blend_r       <= '0;
      retire_r      <= '0;
      count_r       <= '0;
      pend_rd_r     <= '0;
      out_rd_r      <= '0;
      ready_en_r    <= 1'b0;
      in_flight_r   <= 1'b0;
      blend_valid_r <= 1'b0;
      blend_src0_r  <= 32'h0;
      blend_src1_r  <= 32'h0;
      blend_dst_r   <= 32'h0;
      blend_fsel_r  <= 4'h0;
      blend_addr_r  <= '0;
      wr_valid_r    <= 1'b0;
      wr_addr_r     <= '0;
      wr_data_r     <= 32'h0;
      err_rsp_r     <= 1'b0;
    end else begin
      ready_en_r <= 1'b1;
      if (acc_s) begin
        addr_r[alloc_r]   <= bus.frag_addr;
        src0_r[alloc_r]   <= bus.frag_src0;
        src1_r[alloc_r]   <= bus.frag_src1;
        fsel_r[alloc_r]   <= bus.frag_fsel;
        occ_r[alloc_r]    <= 1'b1;
        dst_ok_r[alloc_r] <= 1'b0;
        alloc_r           <= alloc_r + PW'(1);
      end
      if (rd_go_s) begin
        issue_r <= issue_r + PW'(1);
      end
      if (rsp_ok_s) begin
        dst_r[rsp_r]    <= bus.rd_rsp_data;
        dst_ok_r[rsp_r] <= 1'b1;
        rsp_r           <= rsp_r + PW'(1);
      end
      if (rsp_err_s) begin
        err_rsp_r <= 1'b1;
      end
      pend_rd_r <= pend_rd_r + CW'(acc_s) - CW'(rd_go_s);
      out_rd_r  <= out_rd_r + CW'(rd_go_s) - CW'(rsp_ok_s);
      count_r   <= count_r + CW'(acc_s) - CW'(wr_go_s);

      blend_valid_r <= blend_go_s;
      if (blend_go_s) begin
        blend_src0_r <= src0_r[blend_r];
        blend_src1_r <= src1_r[blend_r];
        blend_fsel_r <= fsel_r[blend_r];
        blend_addr_r <= addr_r[blend_r];
        blend_dst_r  <= dst_ok_r[blend_r] ? dst_r[blend_r] : bus.rd_rsp_data;
        blend_r      <= blend_r + PW'(1);
        in_flight_r  <= 1'b1;
      end else if (res_load_s) begin
        in_flight_r <= 1'b0;
      end

      if (res_load_s) begin
        wr_valid_r <= 1'b1;
        wr_addr_r  <= blend_addr_r;
        wr_data_r  <= bus.blend_out_color;
      end else if (wr_go_s) begin
        wr_valid_r <= 1'b0;
      end

      if (wr_go_s) begin
        occ_r[retire_r]    <= 1'b0;
        dst_ok_r[retire_r] <= 1'b0;
        retire_r           <= retire_r + PW'(1);
      end
    end
  end

  assign bus.frag_ready   = frag_ready_s;
  assign bus.rd_req_valid = (pend_rd_r != CW'(0));
  assign bus.rd_req_addr  = addr_r[issue_r];
  assign bus.blend_valid  = blend_valid_r;
  assign bus.blend_src0   = blend_src0_r;
  assign bus.blend_src1   = blend_src1_r;
  assign bus.blend_dst    = blend_dst_r;
  assign bus.blend_fsel   = blend_fsel_r;
  assign bus.wr_valid     = wr_valid_r;
  assign bus.wr_addr      = wr_addr_r;
  assign bus.wr_data      = wr_data_r;
  assign bus.busy         = (count_r != CW'(0)) || wr_valid_r;
  assign bus.err_rsp      = err_rsp_r;
endmodule

// File: tb/tb_rop_rmw_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rop_rmw_ctrl
// Directed bench for rop_rmw_ctrl. Stimulus pushes expected writes (address,
// blended colour from a reference framebuffer) into a queue; a monitor pops
// and compares on every accepted write. A memory model answers reads one
// cycle after acceptance; a blender model answers one cycle after issue with
// src0 ^ src1 ^ dst ^ fsel.
// ---------------------------------------------------------------------------
module tb_rop_rmw_ctrl;
  localparam int AW = 16;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [31:0]   d;
  } wr_t;

  logic clk;
  logic rst_n;
  rop_rmw_ctrl_if #(.ADDR_W(AW)) bus ();

  rop_rmw_ctrl #(.DEPTH(4), .ADDR_W(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  wr_t exp_q[$];
  logic [31:0] mem    [512];
  logic [31:0] ref_fb [512];
  logic inject_rsp = 1'b0;
  int last_blend_cyc = 0;
  int wr_first_cyc = 0;
  int wr_acc_cyc = 0;
  logic [31:0] last_wr_data = 32'h0;
  bit sender_done = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic logic [31:0] blend_fn(logic [31:0] s0, logic [31:0] s1,
                                           logic [31:0] d, logic [3:0] f);
    return s0 ^ s1 ^ d ^ {28'h0, f};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, expv);
    end
  endtask

  // memory read responder: answers one cycle after acceptance
  initial begin : rsp_model
    logic pend;
    logic [AW-1:0] pa;
    pend = 1'b0;
    pa = '0;
    forever begin
      @(negedge clk);
      bus.rd_rsp_valid = pend || inject_rsp;
      bus.rd_rsp_data  = pend ? mem[pa[8:0]] : 32'hBAD0BAD0;
      pend = bus.rd_req_valid && bus.rd_req_ready;
      pa   = bus.rd_req_addr;
    end
  end

  // blender model with fixed one-cycle latency
  initial begin : blend_model
    logic pend;
    logic [31:0] col;
    pend = 1'b0;
    col = 32'h0;
    forever begin
      @(negedge clk);
      bus.blend_out_valid = pend;
      bus.blend_out_color = col;
      pend = bus.blend_valid;
      col  = blend_fn(bus.blend_src0, bus.blend_src1, bus.blend_dst, bus.blend_fsel);
      if (bus.blend_valid) last_blend_cyc = cyc;
    end
  end

  // write monitor / scoreboard
  initial begin : wr_monitor
    logic prev;
    wr_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.wr_valid && !prev) wr_first_cyc = cyc;
      prev = bus.wr_valid && !bus.wr_ready;
      if (bus.wr_valid && bus.wr_ready) begin
        wr_acc_cyc   = cyc;
        last_wr_data = bus.wr_data;
        mem[bus.wr_addr[8:0]] = bus.wr_data;
        if (exp_q.size() == 0) begin
          chk("unexpected_write", {bus.wr_addr, bus.wr_data}, 64'h0);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", bus.wr_addr, e.a);
          chk("wr_data", bus.wr_data, e.d);
        end
      end
    end
  end

  task automatic send_frag(input logic [AW-1:0] a, input logic [31:0] s0,
                           input logic [31:0] s1, input logic [3:0] f,
                           input bit push, output int acc_cyc, output int stall);
    int n;
    wr_t e;
    n = 0;
    @(negedge clk);
    bus.frag_valid = 1'b1;
    bus.frag_addr  = a;
    bus.frag_src0  = s0;
    bus.frag_src1  = s1;
    bus.frag_fsel  = f;
    #1;
    while (!bus.frag_ready && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    stall = n;
    acc_cyc = cyc;
    if (n >= 300) begin
      chk("frag_accept_timeout", 64'(n), 64'h0);
    end else if (push) begin
      e.a = a;
      e.d = blend_fn(s0, s1, ref_fb[a[8:0]], f);
      ref_fb[a[8:0]] = e.d;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.frag_valid = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while ((bus.busy || exp_q.size() != 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_idle_timeout"}, 64'(n >= 400), 64'h0);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_ctl"}, {bus.frag_ready, bus.rd_req_valid, bus.blend_valid,
                       bus.wr_valid, bus.busy, bus.err_rsp}, 64'h0);
    chk({nm, "_addr"}, {bus.wr_addr, bus.rd_req_addr}, 64'h0);
    chk({nm, "_data"}, {bus.wr_data, bus.blend_dst | bus.blend_src0 | bus.blend_src1}, 64'h0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int t;
    int st;
    logic [AW-1:0] ha;
    logic [31:0] hd;
    for (int i = 0; i < 512; i++) begin
      mem[i]    = (i == 16) ? 32'h0 : (32'hD000_0000 | 32'(i));
      ref_fb[i] = mem[i];
    end
    rst_n = 1'b0;
    bus.frag_valid = 1'b0;
    bus.frag_addr = '0;
    bus.frag_src0 = 32'h0;
    bus.frag_src1 = 32'h0;
    bus.frag_fsel = 4'h0;
    bus.rd_req_ready = 1'b1;
    bus.wr_ready = 1'b1;
    bus.rd_rsp_valid = 1'b0;
    bus.rd_rsp_data = 32'h0;
    bus.blend_out_valid = 1'b0;
    bus.blend_out_color = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_reset_ready", {bus.frag_ready, bus.busy}, 64'h2);

    // single fragment, minimum latency
    send_frag(16'h0010, 32'h80FF0000, 32'h92CB5678, 4'h0, 1'b1, t, st);
    wait_idle("t1");
    chk("t1_data_const", last_wr_data, 32'h12345678);
    chk("t1_blend_lat", 64'(last_blend_cyc - t), 64'd3);
    chk("t1_wr_lat", 64'(wr_first_cyc - t), 64'd5);

    // fill with reads blocked
    @(posedge clk); #1; bus.rd_req_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      send_frag(16'h0100 + 16'(i), 32'h01020300 + 32'(i), 32'h0A0B0C0D, 4'(i), 1'b1, t, st);
    @(negedge clk);
    bus.frag_addr = 16'h0104;
    #1;
    chk("t2_full_ready", bus.frag_ready, 1'b0);
    chk("t2_rd_hold", {bus.rd_req_valid, bus.rd_req_addr}, {1'b1, 16'h0100});
    @(posedge clk); #1; bus.rd_req_ready = 1'b1;
    wait_idle("t2");
    chk("t2_busy", bus.busy, 1'b0);

    // same-address hazard
    send_frag(16'h0020, 32'h00000055, 32'h00001100, 4'h3, 1'b1, t, st);
    send_frag(16'h0020, 32'h00AA0000, 32'h22000000, 4'h5, 1'b1, t, st);
    chk("t3_stalled", 64'(st > 0), 64'h1);
    chk("t3_accept_after_wr", 64'(t - wr_acc_cyc), 64'd1);
    wait_idle("t3");

    // write backpressure and pointer wrap
    @(posedge clk); #1; bus.wr_ready = 1'b0;
    sender_done = 1'b0;
    fork
      begin
        int tt, ss;
        for (int i = 0; i < 9; i++)
          send_frag(16'h0040 + 16'(i), 32'h11110000 + 32'(i), 32'h00330000 * 32'(i),
                    4'(i), 1'b1, tt, ss);
        sender_done = 1'b1;
      end
    join_none
    st = 0;
    while (!bus.wr_valid && st < 100) begin
      @(negedge clk);
      st++;
    end
    chk("t4_wr_seen", bus.wr_valid, 1'b1);
    ha = bus.wr_addr;
    hd = bus.wr_data;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t4_hold", {bus.wr_valid, bus.wr_addr, bus.wr_data}, {1'b1, ha, hd});
      chk("t4_no_blend", bus.blend_valid, 1'b0);
    end
    @(posedge clk); #1; bus.wr_ready = 1'b1;
    st = 0;
    while (!sender_done && st < 400) begin
      @(negedge clk);
      st++;
    end
    chk("t4_sender_done", sender_done, 1'b1);
    wait_idle("t4");

    // response with nothing outstanding
    @(posedge clk); #1; inject_rsp = 1'b1;
    @(posedge clk); #1; inject_rsp = 1'b0;
    @(negedge clk);
    chk("t5_err", {bus.err_rsp, bus.busy, bus.rd_req_valid, bus.frag_ready}, 64'h9);

    // reset mid-stream with 3 pending entries
    @(posedge clk); #1; bus.rd_req_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      send_frag(16'h0080 + 16'(i), 32'hCAFE0000, 32'h0000BEEF, 4'h1, 1'b0, t, st);
    chk("t6_busy_before", bus.busy, 1'b1);
    @(posedge clk); #1; rst_n = 1'b0;
    @(posedge clk); #1;
    chk_all_zero("t6_reset");
    rst_n = 1'b1;
    bus.rd_req_ready = 1'b1;
    repeat (10) @(negedge clk);
    chk("t6_after", {bus.busy, bus.rd_req_valid, bus.wr_valid}, 64'h0);
    @(posedge clk); #1; inject_rsp = 1'b1;
    @(posedge clk); #1; inject_rsp = 1'b0;
    @(negedge clk);
    chk("t6_late_rsp_err", bus.err_rsp, 1'b1);
    chk("final_queue_empty", 64'(exp_q.size()), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
